// File: rtl/intc_pkg.sv
// Shared definitions for the interrupt controller: register offsets,
// FSM state encoding, default source count and the bus request bundle.
package intc_pkg;

  localparam int NUM_SRC_DEF = 6;

  localparam logic [2:0] REG_PENDING = 3'd0;
  localparam logic [2:0] REG_MASK    = 3'd2;
  localparam logic [2:0] REG_ISR     = 3'd4;
  localparam logic [2:0] REG_VECTOR  = 3'd6;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_SERVICE = 2'd2
  } intc_state_e;

  typedef struct packed {
    logic        rd;
    logic        wr;
    logic [2:0]  addr;
    logic [15:0] wdata;
  } intc_bus_req_t;

endpackage

// File: rtl/intc_prio_enc.sv
// Fixed-priority encoder: lowest set index wins, reported with a valid flag.
module intc_prio_enc
  import intc_pkg::*;
#(
  parameter int N = NUM_SRC_DEF
) (
  input  logic [N-1:0] req,
  output logic         valid,
  output logic [3:0]   idx
);

  // Scan high to low so the last hit, i.e. the lowest index, is kept.
  always_comb begin
    valid = 1'b0;
    idx   = 4'd0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) begin
        valid = 1'b1;
        idx   = 4'(i);
      end
    end
  end

endmodule

// File: rtl/interrupt_ctrl.sv
// Edge-triggered, maskable, priority interrupt controller with CPU handshake.
// Optional nested preemption from SERVICE is enabled by macro INTC_NESTING_EN.
module interrupt_ctrl
  import intc_pkg::*;
#(
  parameter int NUM_SRC = NUM_SRC_DEF
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [NUM_SRC-1:0] irq_n,
  input  logic               intrCtrl,
  input  logic               read_enable,
  input  logic               write_enable,
  input  logic [2:0]         address,
  input  logic [15:0]        write_data_in,
  output logic [15:0]        read_data_out,
  output logic               int_req,
  input  logic               int_ack,
  output logic [3:0]         int_vector
);

  intc_bus_req_t bus;
  assign bus.rd    = intrCtrl & read_enable;
  assign bus.wr    = intrCtrl & write_enable & ~read_enable;
  assign bus.addr  = address;
  assign bus.wdata = write_data_in;

  logic unused_bus;
  assign unused_bus = ^bus.wdata;

  logic [NUM_SRC-1:0] irq_q, pending, mask, isr;
  logic [NUM_SRC-1:0] edge_set, pending_nxt, isr_nxt, isr_after_eoi;
  logic [NUM_SRC-1:0] vec_hot, top_hot;
  intc_state_e        state, state_nxt;
  logic [3:0]         vec_nxt;
  logic               ack_take;
  logic               wr_pend, wr_mask, eoi;
  logic               cand_valid, isr_valid;
  logic [3:0]         cand_idx, isr_top;
  logic [15:0]        rd_mux;

  assign edge_set = irq_q & ~irq_n;
  assign wr_pend  = bus.wr && (bus.addr == REG_PENDING);
  assign wr_mask  = bus.wr && (bus.addr == REG_MASK);
  assign eoi      = bus.wr && (bus.addr == REG_ISR);

  intc_prio_enc #(.N(NUM_SRC)) u_cand_enc (
    .req   (pending & ~mask),
    .valid (cand_valid),
    .idx   (cand_idx)
  );

  intc_prio_enc #(.N(NUM_SRC)) u_isr_enc (
    .req   (isr),
    .valid (isr_valid),
    .idx   (isr_top)
  );

  always_comb begin
    vec_hot = '0;
    top_hot = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      vec_hot[i] = (int_vector == 4'(i));
      top_hot[i] = isr_valid && (isr_top == 4'(i));
    end
  end

  assign isr_after_eoi = isr & ~(eoi ? top_hot : '0);

  always_comb begin
    state_nxt = state;
    vec_nxt   = int_vector;
    ack_take  = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (cand_valid) begin
          state_nxt = ST_REQ;
          vec_nxt   = cand_idx;
        end
      end
      ST_REQ: begin
        if (int_ack) begin
          ack_take  = 1'b1;
          state_nxt = ST_SERVICE;
        end
      end
      ST_SERVICE: begin
        if (eoi) begin
          if (isr_after_eoi == '0) state_nxt = ST_IDLE;
        end
`ifdef INTC_NESTING_EN
        // Only a strictly higher-priority source may preempt the active one.
        else if (cand_valid && isr_valid && (cand_idx < isr_top)) begin
          state_nxt = ST_REQ;
          vec_nxt   = cand_idx;
        end
`endif
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // A fresh edge beats both the W1C clear and the acknowledge clear.
  assign pending_nxt = (pending
                        & ~(wr_pend ? bus.wdata[NUM_SRC-1:0] : '0)
                        & ~(ack_take ? vec_hot : '0))
                       | edge_set;
  assign isr_nxt = isr_after_eoi | (ack_take ? vec_hot : '0);

  always_comb begin
    rd_mux = 16'h0000;
    case (bus.addr)
      REG_PENDING: rd_mux = 16'(pending);
      REG_MASK:    rd_mux = 16'(mask);
      REG_ISR:     rd_mux = 16'(isr);
      REG_VECTOR:  rd_mux = {12'h000, int_vector};
      default:     rd_mux = 16'h0000;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      irq_q         <= '1;
      pending       <= '0;
      mask          <= '1;
      isr           <= '0;
      state         <= ST_IDLE;
      int_vector    <= 4'd0;
      read_data_out <= 16'h0000;
    end else begin
      irq_q      <= irq_n;
      pending    <= pending_nxt;
      isr        <= isr_nxt;
      state      <= state_nxt;
      int_vector <= vec_nxt;
      if (wr_mask) mask <= bus.wdata[NUM_SRC-1:0];
      if (bus.rd) read_data_out <= rd_mux;
    end
  end

  assign int_req = (state == ST_REQ);

endmodule

// File: tb/tb_interrupt_ctrl.sv
// Bench for interrupt_ctrl: directed vector table, hand sequences for nesting
// and reset, then randomized traffic against a behavioural model.
module tb_interrupt_ctrl;

  localparam int N = 6;

  logic          clock = 1'b0;
  logic          reset;
  logic [N-1:0]  irq_n;
  logic          intrCtrl, read_enable, write_enable, int_ack;
  logic [2:0]    address;
  logic [15:0]   write_data_in, read_data_out;
  logic          int_req;
  logic [3:0]    int_vector;

  int n_pass = 0;
  int n_chk  = 0;

  always #5 clock = ~clock;

  interrupt_ctrl #(.NUM_SRC(N)) dut (
    .clock         (clock),
    .reset         (reset),
    .irq_n         (irq_n),
    .intrCtrl      (intrCtrl),
    .read_enable   (read_enable),
    .write_enable  (write_enable),
    .address       (address),
    .write_data_in (write_data_in),
    .read_data_out (read_data_out),
    .int_req       (int_req),
    .int_ack       (int_ack),
    .int_vector    (int_vector)
  );

  typedef struct {
    logic [5:0]  irq;
    logic        cs, rd, wr;
    logic [2:0]  addr;
    logic [15:0] wd;
    logic        ack;
    logic        ereq;
    logic [3:0]  evec;
    logic        chk_rd;
    logic [15:0] erd;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic [5:0] irq, logic cs, logic rd, logic wr,
                              logic [2:0] addr, logic [15:0] wd, logic ack,
                              logic ereq, logic [3:0] evec, logic chk_rd,
                              logic [15:0] erd);
    vec_t v;
    v.irq = irq; v.cs = cs; v.rd = rd; v.wr = wr; v.addr = addr; v.wd = wd;
    v.ack = ack; v.ereq = ereq; v.evec = evec; v.chk_rd = chk_rd; v.erd = erd;
    return v;
  endfunction

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%04h expected 0x%04h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic [5:0] irq, input logic cs, input logic rd, input logic wr,
                       input logic [2:0] addr, input logic [15:0] wd, input logic ack);
    irq_n = irq; intrCtrl = cs; read_enable = rd; write_enable = wr;
    address = addr; write_data_in = wd; int_ack = ack;
  endtask

  task automatic idle(input logic [5:0] irq);
    drive(irq, 1'b0, 1'b0, 1'b0, 3'd0, 16'h0, 1'b0);
  endtask

  task automatic bus_wr(input logic [5:0] irq, input logic [2:0] addr, input logic [15:0] wd);
    drive(irq, 1'b1, 1'b0, 1'b1, addr, wd, 1'b0);
  endtask

  task automatic bus_rd(input logic [5:0] irq, input logic [2:0] addr);
    drive(irq, 1'b1, 1'b1, 1'b0, addr, 16'h0, 1'b0);
  endtask

  // Behavioural reference: registers as plain integers, one step per clock.
  int m_pend, m_mask, m_isr, m_phase, m_vec, m_rd, m_prev;

  function automatic int lowest(input int v);
    for (int i = 0; i < N; i++) if (v[i]) return i;
    return -1;
  endfunction

  task automatic model_step();
    int edges, cand, top, np, nm, ni, nph, nv;
    bit rd, wr, eoi;
    if (reset) begin
      m_pend = 0; m_mask = 63; m_isr = 0; m_phase = 0; m_vec = 0; m_rd = 0; m_prev = 63;
      return;
    end
    edges = m_prev & ~int'(irq_n) & 63;
    rd  = intrCtrl && read_enable;
    wr  = intrCtrl && write_enable && !read_enable;
    eoi = wr && (address == 3'd4);
    cand = lowest(m_pend & ~m_mask);
    top  = lowest(m_isr);
    if (rd) begin
      case (address)
        3'd0:    m_rd = m_pend;
        3'd2:    m_rd = m_mask;
        3'd4:    m_rd = m_isr;
        3'd6:    m_rd = m_vec;
        default: m_rd = 0;
      endcase
    end
    np = m_pend; nm = m_mask; ni = m_isr; nph = m_phase; nv = m_vec;
    if (wr && address == 3'd0) np = np & ~int'(write_data_in);
    if (wr && address == 3'd2) nm = int'(write_data_in) & 63;
    if (eoi && top >= 0) ni = ni & ~(1 << top);
    case (m_phase)
      0: if (cand >= 0) begin nph = 1; nv = cand; end
      1: if (int_ack) begin
           np = np & ~(1 << m_vec);
           ni = ni | (1 << m_vec);
           nph = 2;
         end
      default: begin
        if (eoi) begin
          if (ni == 0) nph = 0;
        end
`ifdef INTC_NESTING_EN
        else if (cand >= 0 && top >= 0 && cand < top) begin
          nph = 1; nv = cand;
        end
`endif
      end
    endcase
    m_pend = np | edges; m_mask = nm; m_isr = ni; m_phase = nph; m_vec = nv;
    m_prev = int'(irq_n);
  endtask

  initial begin
    drive(6'h3F, 1'b0, 1'b0, 1'b0, 3'd0, 16'h0, 1'b0);
    reset = 1'b1;
    tick(); tick();
    check("reset.int_req", 16'(int_req), 16'h0);
    check("reset.int_vector", 16'(int_vector), 16'h0);
    check("reset.read_data_out", read_data_out, 16'h0);
    reset = 1'b0;

    //            irq    cs rd wr addr wd      ack req vec chk rd_exp
    tbl.push_back(mk(6'h3F,1,1,0,3'd2,16'h0000,0, 0,4'd0,1,16'h003F));
    tbl.push_back(mk(6'h3F,1,0,1,3'd2,16'h0000,0, 0,4'd0,0,16'h0000));
    tbl.push_back(mk(6'h3D,0,0,0,3'd0,16'h0000,0, 0,4'd0,0,16'h0000));
    tbl.push_back(mk(6'h3D,1,1,0,3'd0,16'h0000,0, 1,4'd1,1,16'h0002));
    tbl.push_back(mk(6'h3D,0,0,0,3'd0,16'h0000,1, 0,4'd1,0,16'h0000));
    tbl.push_back(mk(6'h3D,1,1,0,3'd4,16'h0000,0, 0,4'd1,1,16'h0002));
    tbl.push_back(mk(6'h3D,1,1,0,3'd0,16'h0000,0, 0,4'd1,1,16'h0000));
    tbl.push_back(mk(6'h3D,1,1,0,3'd6,16'h0000,0, 0,4'd1,1,16'h0001));
    tbl.push_back(mk(6'h3F,1,0,1,3'd4,16'h0000,0, 0,4'd1,0,16'h0000));
    tbl.push_back(mk(6'h3F,1,1,0,3'd4,16'h0000,0, 0,4'd1,1,16'h0000));
    tbl.push_back(mk(6'h35,0,0,0,3'd0,16'h0000,0, 0,4'd1,0,16'h0000));
    tbl.push_back(mk(6'h35,0,0,0,3'd0,16'h0000,0, 1,4'd1,0,16'h0000));
    tbl.push_back(mk(6'h35,0,0,0,3'd0,16'h0000,1, 0,4'd1,0,16'h0000));
    tbl.push_back(mk(6'h35,1,1,0,3'd0,16'h0000,0, 0,4'd1,1,16'h0008));
    tbl.push_back(mk(6'h35,1,0,1,3'd4,16'h0000,0, 0,4'd1,0,16'h0000));
    tbl.push_back(mk(6'h35,0,0,0,3'd0,16'h0000,0, 1,4'd3,0,16'h0000));
    tbl.push_back(mk(6'h35,0,0,0,3'd0,16'h0000,1, 0,4'd3,0,16'h0000));
    tbl.push_back(mk(6'h35,1,0,1,3'd4,16'h0000,0, 0,4'd3,0,16'h0000));
    tbl.push_back(mk(6'h3F,0,0,0,3'd0,16'h0000,0, 0,4'd3,0,16'h0000));
    tbl.push_back(mk(6'h3F,1,0,1,3'd2,16'h0004,0, 0,4'd3,0,16'h0000));
    tbl.push_back(mk(6'h3B,0,0,0,3'd0,16'h0000,0, 0,4'd3,0,16'h0000));
    tbl.push_back(mk(6'h3B,1,1,0,3'd0,16'h0000,0, 0,4'd3,1,16'h0004));
    tbl.push_back(mk(6'h3B,0,0,0,3'd0,16'h0000,0, 0,4'd3,0,16'h0000));
    tbl.push_back(mk(6'h3B,1,0,1,3'd2,16'h0000,0, 0,4'd3,0,16'h0000));
    tbl.push_back(mk(6'h3B,0,0,0,3'd0,16'h0000,0, 1,4'd2,0,16'h0000));
    tbl.push_back(mk(6'h3F,0,0,0,3'd0,16'h0000,0, 1,4'd2,0,16'h0000));
    tbl.push_back(mk(6'h3B,1,0,1,3'd0,16'h0004,0, 1,4'd2,0,16'h0000));
    tbl.push_back(mk(6'h3B,1,1,0,3'd0,16'h0000,0, 1,4'd2,1,16'h0004));
    tbl.push_back(mk(6'h3B,1,0,1,3'd0,16'h0004,0, 1,4'd2,0,16'h0000));
    tbl.push_back(mk(6'h3B,1,1,0,3'd0,16'h0000,0, 1,4'd2,1,16'h0000));
    tbl.push_back(mk(6'h3B,1,1,1,3'd2,16'h003F,0, 1,4'd2,1,16'h0000));
    tbl.push_back(mk(6'h3B,1,1,0,3'd2,16'h0000,0, 1,4'd2,1,16'h0000));
    tbl.push_back(mk(6'h3B,0,0,1,3'd2,16'h003F,0, 1,4'd2,0,16'h0000));
    tbl.push_back(mk(6'h3B,1,1,0,3'd2,16'h0000,0, 1,4'd2,1,16'h0000));
    tbl.push_back(mk(6'h3B,0,0,0,3'd0,16'h0000,1, 0,4'd2,0,16'h0000));
    tbl.push_back(mk(6'h3B,1,0,1,3'd6,16'h000F,0, 0,4'd2,0,16'h0000));
    tbl.push_back(mk(6'h3B,1,1,0,3'd6,16'h0000,0, 0,4'd2,1,16'h0002));
    tbl.push_back(mk(6'h3B,1,0,1,3'd4,16'h0000,0, 0,4'd2,0,16'h0000));
    tbl.push_back(mk(6'h3B,1,1,0,3'd1,16'h0000,0, 0,4'd2,1,16'h0000));
    tbl.push_back(mk(6'h3B,0,0,0,3'd0,16'h0000,1, 0,4'd2,0,16'h0000));
    tbl.push_back(mk(6'h3B,1,1,0,3'd4,16'h0000,0, 0,4'd2,1,16'h0000));

    foreach (tbl[k]) begin
      drive(tbl[k].irq, tbl[k].cs, tbl[k].rd, tbl[k].wr, tbl[k].addr, tbl[k].wd, tbl[k].ack);
      tick();
      check($sformatf("tbl[%0d].int_req", k), 16'(int_req), 16'(tbl[k].ereq));
      check($sformatf("tbl[%0d].int_vector", k), 16'(int_vector), 16'(tbl[k].evec));
      if (tbl[k].chk_rd)
        check($sformatf("tbl[%0d].read_data", k), read_data_out, tbl[k].erd);
    end

    // Source 4 in service, source 0 arrives.
    idle(6'h3F); tick();
    idle(6'h2F); tick();
    tick();
    check("nest.req4", 16'(int_req), 16'h1);
    check("nest.vec4", 16'(int_vector), 16'h4);
    drive(6'h2F, 1'b0, 1'b0, 1'b0, 3'd0, 16'h0, 1'b1); tick();
    idle(6'h2E); tick();
    tick();
`ifdef INTC_NESTING_EN
    check("nest.preempt_req", 16'(int_req), 16'h1);
    check("nest.preempt_vec", 16'(int_vector), 16'h0);
    drive(6'h2E, 1'b0, 1'b0, 1'b0, 3'd0, 16'h0, 1'b1); tick();
    bus_rd(6'h2E, 3'd4); tick();
    check("nest.isr", read_data_out, 16'h0011);
    bus_wr(6'h2E, 3'd4, 16'h0); tick();
    bus_wr(6'h2E, 3'd4, 16'h0); tick();
    idle(6'h2E); tick();
    check("nest.idle_after_eoi", 16'(int_req), 16'h0);
`else
    check("nest.held_req", 16'(int_req), 16'h0);
    idle(6'h2E); tick();
    check("nest.held_req2", 16'(int_req), 16'h0);
    bus_rd(6'h2E, 3'd4); tick();
    check("nest.isr", read_data_out, 16'h0010);
    bus_wr(6'h2E, 3'd4, 16'h0); tick();
    check("nest.eoi_req", 16'(int_req), 16'h0);
    idle(6'h2E); tick();
    check("nest.after_eoi_req", 16'(int_req), 16'h1);
    check("nest.after_eoi_vec", 16'(int_vector), 16'h0);
`endif

    // Reset while a request is outstanding.
    reset = 1'b1; idle(6'h3F); tick();
    reset = 1'b0; bus_wr(6'h3F, 3'd2, 16'h0); tick();
    idle(6'h1F); tick();
    tick();
    check("rst.pre_req", 16'(int_req), 16'h1);
    check("rst.pre_vec", 16'(int_vector), 16'h5);
    reset = 1'b1; idle(6'h3F); tick();
    check("rst.int_req", 16'(int_req), 16'h0);
    check("rst.int_vector", 16'(int_vector), 16'h0);
    reset = 1'b0; bus_rd(6'h3F, 3'd2); tick();
    check("rst.mask", read_data_out, 16'h003F);
    bus_rd(6'h3F, 3'd0); tick();
    check("rst.pending", read_data_out, 16'h0000);

    // Randomized traffic against the model.
    reset = 1'b1; idle(6'h3F);
    model_step(); tick();
    for (int c = 0; c < 600; c++) begin
      logic [5:0] irq;
      irq = irq_n;
      for (int b = 0; b < N; b++) if ($urandom_range(0, 7) == 0) irq[b] = ~irq[b];
      reset = ($urandom_range(0, 149) == 0);
      irq_n = irq;
      intrCtrl = ($urandom_range(0, 3) != 0);
      read_enable = ($urandom_range(0, 3) == 0);
      write_enable = ($urandom_range(0, 3) == 0);
      address = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(0, 7))
                                            : {2'($urandom_range(0, 3)), 1'b0};
      write_data_in = 16'($urandom);
      int_ack = ($urandom_range(0, 2) == 0);
      model_step();
      tick();
      check($sformatf("rnd[%0d].int_req", c), 16'(int_req), 16'(m_phase == 1));
      check($sformatf("rnd[%0d].int_vector", c), 16'(int_vector), 16'(m_vec));
      check($sformatf("rnd[%0d].read_data", c), read_data_out, 16'(m_rd));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/interrupt_ctrl.md
INTERRUPT_CTRL -- requirements
Module: interrupt_ctrl

Interface
REQ-001 SHALL have parameter NUM_SRC, default 6, number of interrupt sources (1..16); source 0 is highest priority.
REQ-002 SHALL have port clock  input  1  system clock; all logic on posedge clock.
REQ-003 SHALL have port reset  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port irq_n  input  NUM_SRC  interrupt lines, active-low, clock-synchronous (CTC0_output/CTC1_output on bits 0/1).
REQ-005 SHALL have port intrCtrl  input  1  chip select for this block's register window.
REQ-006 SHALL have port read_enable / write_enable  input  1 each  bus read / write strobes.
REQ-007 SHALL have port address  input  3  register select: 0 pending, 2 mask, 4 in-service/EOI, 6 vector.
REQ-008 SHALL have port write_data_in  input  16  bus write data.
REQ-009 SHALL have port read_data_out  output  16  registered bus read data.
REQ-010 SHALL have port int_req  output  1  interrupt request to CPU, active-high.
REQ-011 SHALL have port int_ack  input  1  CPU acknowledge, single-cycle high.
REQ-012 SHALL have port int_vector  output  4  index of requested source.

Function
REQ-013 SHALL register irq_n each cycle; falling edge = irq_q[i]=1 and irq_n[i]=0; pending[i] set at that posedge.
REQ-014 SHALL access registers only when intrCtrl=1; read_enable takes precedence over write_enable in the same cycle.
REQ-015 SHALL update read_data_out at the posedge of a read, zero-extended: 0 pending, 2 mask, 4 isr, 6 {12'b0,int_vector}; hold otherwise; unused addresses return 0.
REQ-016 SHALL treat write to 0 as write-1-to-clear of pending; edge-set of same bit in same cycle wins.
REQ-017 SHALL load mask from write to 2 (1 = masked); masked sources stay pending, never requested.
REQ-018 SHALL treat write to 4 (any data) as EOI: clear highest-priority set isr bit; write to 6 ignored.
REQ-019 SHALL define candidate = lowest index i with pending[i] & ~mask[i].
REQ-020 SHALL implement FSM IDLE/REQ/SERVICE; IDLE->REQ when candidate exists: latch int_vector, int_req=1 next posedge.
REQ-021 SHALL in REQ hold int_req and int_vector stable regardless of mask/pending changes until int_ack=1.
REQ-022 SHALL on int_ack in REQ: clear pending[int_vector], set isr[int_vector], int_req=0, go SERVICE, same posedge.
REQ-023 SHALL ignore int_ack outside REQ.
REQ-024 SHALL in SERVICE, after EOI, go IDLE if isr becomes zero, else stay SERVICE.
REQ-025 SHALL give minimum latency: irq_n low at posedge N -> pending at N -> int_req high after N+1.

Reset
REQ-026 SHALL on reset: pending=0, isr=0, mask=all ones, irq_q=all ones, int_req=0, int_vector=0, read_data_out=0, state IDLE.
REQ-027 SHALL let reset override any access or handshake in progress, including REQ with int_req high.

Configuration
REQ-028 SHALL honour macro INTC_NESTING_EN: when defined, SERVICE->REQ when candidate index < highest-priority isr index; pending edges of lower priority wait.
REQ-029 SHALL without INTC_NESTING_EN never leave SERVICE except via EOI/reset; isr holds at most one bit.

Structure
REQ-030 SHALL place register offsets (0/2/4/6), FSM state encodings and NUM_SRC default in shared package intc_pkg.
REQ-031 SHALL implement priority selection as sub-module intc_prio_enc (NUM_SRC request bits -> valid + 4-bit index).

Verification
REQ-032 SHALL test: mask write 0x0000, irq_n[1] falls at cycle 10 -> pending=0x0002 at 10, int_req=1 and int_vector=1 at 11.
REQ-033 SHALL test: irq_n[3],[1] fall together, unmasked -> int_vector=1; after ack+EOI -> int_vector=3.
REQ-034 SHALL test: mask=0x0004, irq_n[2] falls -> pending=0x0004, int_req stays 0; mask write 0x0000 -> int_req=1, int_vector=2.
REQ-035 SHALL test: int_req=1, W1C 0x0004 and edge on bit 2 in same cycle -> pending bit 2 remains 1.
REQ-036 SHALL test: in SERVICE for source 4, irq_n[0] falls -> with INTC_NESTING_EN int_req=1 vector 0, isr=0x0011 after ack; without, int_req=0 until EOI.
REQ-037 SHALL test: reset asserted while int_req=1 -> int_req=0, mask=0x003F, pending=0 after that posedge.
